lsu: RTL and testbench
======================

# lsu

Load/store unit forming the MEM stage of the RV32 core. It is directly downstream of the ALU. It consumes the ALU result either as an effective address (loads and stores) or as a pass-through value (all other ops). It drives a request/grant/response data-memory port and produces a registered writeback record for the WB stage. It stalls the pipeline while a memory access is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ or RSP before bus error; 0 disables watchdog

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_mem_op  in  memOp_e  memory operation (MEM_NONE for non-memory ops)
- ex_alu_result  in  32  ALU output: address or pass-through value
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- lsu_stall  out  1  high while EX must hold its outputs
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_gnt  in  1  memory accepted request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_valid  out  1  writeback record valid (1-cycle pulse)
- wb_rd  out  5  destination register (0 for stores)
- wb_data  out  32  result
- exc_valid  out  1  exception pulse
- exc_cause  out  2  1 = misaligned, 2 = bus timeout
- exc_addr  out  32  faulting byte address

## Operation
- FSM states are IDLE, REQ, RSP.
- Reset state is IDLE. All outputs reset to 0.
- IDLE, ex_valid, MEM_NONE: register {rd, alu_result}. The next cycle has wb_valid=1, wb_data=alu_result. The state stays IDLE.
- IDLE, ex_valid, load/store, aligned: latch op, address, store data and rd. Go to REQ.
- IDLE, ex_valid, misaligned: no dmem_req is issued. The next cycle has exc_valid=1, cause 1, exc_addr=address, and wb_valid=0.
  - Halfword ops are misaligned when addr[0]=1.
  - Word ops are misaligned when addr[1:0]!=0.
- REQ: dmem_req=1, with address, write data and strobe held stable until grant.
  - On dmem_gnt with a store: go to IDLE. The next cycle has wb_valid=1 and wb_rd=0.
  - On dmem_gnt with a load: go to RSP.
- RSP: wait for dmem_rvalid. On rvalid:
  - extract the lane selected by addr[1:0];
  - sign-extend for LB/LH, zero-extend for LBU/LHU;
  - the next cycle has wb_valid=1;
  - go to IDLE.
  - rvalid outside RSP is ignored.
- Store lanes:
  - SB: data byte replicated to all lanes, wstrb=4'b0001<<addr[1:0].
  - SH: halfword replicated, wstrb=4'b0011<<addr[1:0].
  - SW: wstrb=4'b1111.
- Watchdog:
  - A counter clears on entry to REQ or RSP and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES with no gnt/rvalid: go to IDLE, exc_valid=1 with cause 2 next cycle, no writeback.
- lsu_stall = (state != IDLE) || (ex_valid && memory op && aligned).
  - EX holds its outputs while lsu_stall is high.
  - ex_valid arriving while not IDLE is ignored; EX guarantees it is held.
- Reset mid-access returns to IDLE immediately and drops dmem_req. Any late gnt/rvalid is ignored.

## Timing
- Pass-through latency is 1 cycle.
- Store latency is 1 + grant wait cycles, then wb_valid on the following cycle. With gnt in the first REQ cycle: accept at T, req at T+1, wb_valid at T+2.
- Load latency is accept at T, req at T+1, gnt at T+1, rvalid at T+1+n, wb_valid at T+2+n.
- Grant and rvalid in the same cycle as the first REQ cycle is illegal from memory; the response must come at least 1 cycle after grant.
- wb_valid and exc_valid are never high together. Each is a single-cycle pulse.

## Structure
- Add to types.svh, alongside aluCtrl_e:
  - memOp_e: MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW;
  - lsuState_e;
  - exception cause constants.
- One combinational sub-module, lsu_align. It performs store lane shift and wstrb generation, load lane extract and extension, and the misalignment check. It is instantiated once, and the FSM and watchdog stay in lsu.

## Test plan
- Pass-through: MEM_NONE, alu_result=0xDEADBEEF, rd=5. Required: wb_valid next cycle, wb_data=0xDEADBEEF, no dmem_req.
- SB to 0x1003 with data 0x000000A5. Required: dmem_addr=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5, wb_rd=0.
- LB from 0x2001 with rdata=0x1234_80FF and 3-cycle rvalid delay. Required: wb_data=0xFFFFFF80. LBU under the same conditions returns 0x00000080.
- Misaligned LW at 0x3002. Required: no dmem_req, exc_valid with cause 1, exc_addr=0x3002.
- Grant withheld for 4 cycles on SW. Required: dmem_req and address held stable, lsu_stall high throughout. TIMEOUT_CYCLES=3 instead gives exc cause 2.
- Reset asserted in RSP. Required: outputs go to 0 at once, and an rvalid pulse after reset produces no wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: memory-op, FSM-state and exception-cause types shared by the load/store unit.
package lsu_pkg;
  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } memOp_e;
  typedef enum logic [1:0] {IDLE, REQ, RSP} lsuState_e;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  function automatic logic is_store(memOp_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/grant/response data-memory port.
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes, load lane extract/extension, misalignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  memOp_e      op,
  input  logic [1:0]  lane,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ldata,
  output logic        misaligned
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {lane, 3'b000};
    wdata = op == MEM_SB ? {4{sdata[7:0]}} : op == MEM_SH ? {2{sdata[15:0]}} : sdata;
    wstrb = op == MEM_SB ? 4'b0001 << lane : op == MEM_SH ? 4'b0011 << lane :
            op == MEM_SW ? 4'b1111 : 4'b0000;
    ldata = op == MEM_LB  ? {{24{sh[7]}}, sh[7:0]} :
            op == MEM_LBU ? {24'b0, sh[7:0]} :
            op == MEM_LH  ? {{16{sh[15]}}, sh[15:0]} :
            op == MEM_LHU ? {16'b0, sh[15:0]} : rdata;
    misaligned = (op inside {MEM_LH, MEM_LHU, MEM_SH} && lane[0]) ||
                 (op inside {MEM_LW, MEM_SW} && lane != 2'b00);
  end
endmodule

// File: rtl/lsu.sv
// lsu: MEM stage; issues data-memory accesses, stalls EX while busy, emits a registered writeback record.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  memOp_e      ex_mem_op,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  output logic        lsu_stall,
  lsu_if.master       dmem,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);
  lsuState_e state_q, state_d;
  memOp_e op_q, op_d, op_sel;
  logic [31:0] addr_q, addr_d, sdata_q, sdata_d, cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d, wb_rd_d;
  logic [31:0] wb_data_d, exc_addr_d, al_wdata, al_ldata;
  logic [3:0] al_wstrb;
  logic [1:0] lane, exc_cause_d;
  logic wb_valid_d, exc_valid_d, misaligned, accept, mem, go, timeout;
  // In IDLE the aligner checks the incoming op; otherwise it serves the latched access.
  assign op_sel = state_q == IDLE ? ex_mem_op : op_q;
  assign lane   = state_q == IDLE ? ex_alu_result[1:0] : addr_q[1:0];
  lsu_align u_align (
    .op(op_sel), .lane(lane), .sdata(sdata_q), .rdata(dmem.rdata),
    .wdata(al_wdata), .wstrb(al_wstrb), .ldata(al_ldata), .misaligned(misaligned)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    accept  = ex_valid && state_q == IDLE;
    mem     = ex_mem_op != MEM_NONE;
    go      = accept && mem && !misaligned;
    timeout = TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES;
    state_d = state_q == IDLE ? (go ? REQ : IDLE) :
              state_q == REQ  ? (dmem.gnt ? (is_store(op_q) ? IDLE : RSP) : timeout ? IDLE : REQ) :
                                (dmem.rvalid || timeout ? IDLE : RSP);
  end
  always_comb begin
    lsu_stall   = state_q != IDLE || (ex_valid && mem && !misaligned);
    dmem.req    = state_q == REQ;
    dmem.we     = dmem.req && is_store(op_q);
    dmem.addr   = dmem.req ? {addr_q[31:2], 2'b00} : 32'b0;
    dmem.wdata  = dmem.req ? al_wdata : 32'b0;
    dmem.wstrb  = dmem.req ? al_wstrb : 4'b0;
    op_d        = go ? ex_mem_op : op_q;
    addr_d      = go ? ex_alu_result : addr_q;
    sdata_d     = go ? ex_store_data : sdata_q;
    rd_d        = go ? ex_rd : rd_q;
    cnt_d       = state_q == IDLE || state_d != state_q ? 32'b0 : cnt_q + 32'd1;
    wb_valid_d  = (accept && !mem) || (dmem.req && dmem.gnt && is_store(op_q)) ||
                  (state_q == RSP && dmem.rvalid);
    wb_rd_d     = !wb_valid_d ? 5'd0 : state_q == IDLE ? ex_rd : is_store(op_q) ? 5'd0 : rd_q;
    wb_data_d   = !wb_valid_d ? 32'b0 : state_q == IDLE ? ex_alu_result :
                  state_q == RSP ? al_ldata : 32'b0;
    // A grant or response arriving on the timeout cycle still wins.
    exc_valid_d = (accept && mem && misaligned) ||
                  (timeout && ((dmem.req && !dmem.gnt) || (state_q == RSP && !dmem.rvalid)));
    exc_cause_d = !exc_valid_d ? 2'd0 : state_q == IDLE ? EXC_MISALIGN : EXC_TIMEOUT;
    exc_addr_d  = !exc_valid_d ? 32'b0 : state_q == IDLE ? ex_alu_result : addr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q      <= MEM_NONE;
      addr_q    <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      op_q      <= op_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wb_valid  <= wb_valid_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      exc_valid <= exc_valid_d;
      exc_cause <= exc_cause_d;
      exc_addr  <= exc_addr_d;
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu; a second instance with a short watchdog covers bus timeout.
module tb_lsu;
  import lsu_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic ex_valid, ex_valid_b;
  memOp_e ex_mem_op;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0] ex_rd;
  logic lsu_stall, wb_valid, exc_valid, lsu_stall_b, wb_valid_b, exc_valid_b;
  logic [4:0] wb_rd, wb_rd_b;
  logic [31:0] wb_data, exc_addr, wb_data_b, exc_addr_b;
  logic [1:0] exc_cause, exc_cause_b;
  lsu_if dmem();
  lsu_if dmem_b();
  lsu u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .lsu_stall(lsu_stall), .dmem(dmem), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );
  lsu #(.TIMEOUT_CYCLES(3)) u_dut_to (
    .clk(clk), .rst(rst), .ex_valid(ex_valid_b), .ex_mem_op(ex_mem_op),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .lsu_stall(lsu_stall_b), .dmem(dmem_b), .wb_valid(wb_valid_b), .wb_rd(wb_rd_b),
    .wb_data(wb_data_b), .exc_valid(exc_valid_b), .exc_cause(exc_cause_b), .exc_addr(exc_addr_b)
  );
  typedef struct {
    logic        is_exc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data, input logic chk_data);
    q.push_back('{1'b0, rd, data, chk_data, 2'd0, 32'd0});
  endtask
  task automatic push_exc(input logic [1:0] cause, input logic [31:0] addr);
    q.push_back('{1'b1, 5'd0, 32'd0, 1'b0, cause, addr});
  endtask
  always @(negedge clk)
    if (!rst && (wb_valid || exc_valid)) begin
      if (q.size() == 0) chk("unexpected_out", {30'b0, wb_valid, exc_valid}, 32'd0);
      else begin
        e = q.pop_front();
        if (e.is_exc) begin
          chk("exc_valid", 32'(exc_valid), 32'd1);
          chk("exc_cause", 32'(exc_cause), 32'(e.cause));
          chk("exc_addr", exc_addr, e.addr);
          chk("exc_no_wb", 32'(wb_valid), 32'd0);
        end else begin
          chk("wb_valid", 32'(wb_valid), 32'd1);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          if (e.chk_data) chk("wb_data", wb_data, e.data);
          chk("wb_no_exc", 32'(exc_valid), 32'd0);
        end
      end
    end
  task automatic issue(input memOp_e op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_mem_op = op;
    ex_alu_result = addr;
    ex_store_data = sdata;
    ex_rd = rd;
    #1 chk("accept_stall", 32'(lsu_stall), 32'd1);
    step();
    ex_valid = 1'b0;
  endtask
  task automatic store(input memOp_e op, input logic [31:0] addr, input logic [31:0] sdata,
                       input int wait_cyc, input logic [31:0] e_addr, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata);
    issue(op, addr, sdata, 5'd7);
    for (int i = 0; i <= wait_cyc; i++) begin
      chk("st_req", 32'(dmem.req), 32'd1);
      chk("st_we", 32'(dmem.we), 32'd1);
      chk("st_addr", dmem.addr, e_addr);
      chk("st_wstrb", 32'(dmem.wstrb), 32'(e_strb));
      chk("st_wdata", dmem.wdata, e_wdata);
      chk("st_stall", 32'(lsu_stall), 32'd1);
      if (i < wait_cyc) step();
    end
    dmem.gnt = 1'b1;
    push_wb(5'd0, 32'd0, 1'b0);
    step();
    dmem.gnt = 1'b0;
  endtask
  task automatic load(input memOp_e op, input logic [31:0] addr, input logic [31:0] rdata,
                      input int n, input logic [4:0] rd, input logic [31:0] e_data);
    issue(op, addr, 32'd0, rd);
    chk("ld_req", 32'(dmem.req), 32'd1);
    chk("ld_we", 32'(dmem.we), 32'd0);
    chk("ld_wstrb", 32'(dmem.wstrb), 32'd0);
    chk("ld_addr", dmem.addr, {addr[31:2], 2'b00});
    dmem.gnt = 1'b1;
    step();
    dmem.gnt = 1'b0;
    repeat (n - 1) begin
      chk("ld_rsp_stall", 32'(lsu_stall), 32'd1);
      chk("ld_rsp_noreq", 32'(dmem.req), 32'd0);
      step();
    end
    dmem.rvalid = 1'b1;
    dmem.rdata = rdata;
    push_wb(rd, e_data, 1'b1);
    step();
    dmem.rvalid = 1'b0;
  endtask
  logic found;
  logic [1:0] to_cause;
  logic [31:0] to_addr;
  logic to_wb;
  initial begin
    ex_valid = 1'b0; ex_valid_b = 1'b0; ex_mem_op = MEM_NONE;
    ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    dmem_b.gnt = 1'b0; dmem_b.rvalid = 1'b0; dmem_b.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    step();
    ex_valid = 1'b1; ex_mem_op = MEM_NONE; ex_alu_result = 32'hDEADBEEF; ex_rd = 5'd5;
    push_wb(5'd5, 32'hDEADBEEF, 1'b1);
    #1 chk("pt_stall", 32'(lsu_stall), 32'd0);
    step();
    ex_valid = 1'b0;
    chk("pt_noreq", 32'(dmem.req), 32'd0);
    step();
    store(MEM_SB, 32'h1003, 32'h000000A5, 0, 32'h1000, 4'b1000, 32'hA5A5A5A5);
    store(MEM_SH, 32'h100A, 32'h0000BEEF, 1, 32'h1008, 4'b1100, 32'hBEEFBEEF);
    store(MEM_SW, 32'h4008, 32'h11223344, 4, 32'h4008, 4'b1111, 32'h11223344);
    load(MEM_LB, 32'h2001, 32'h123480FF, 3, 5'd10, 32'hFFFFFF80);
    load(MEM_LBU, 32'h2001, 32'h123480FF, 3, 5'd11, 32'h00000080);
    load(MEM_LH, 32'h5002, 32'h80017777, 1, 5'd12, 32'hFFFF8001);
    load(MEM_LHU, 32'h5002, 32'h80017777, 2, 5'd13, 32'h00008001);
    load(MEM_LW, 32'h5004, 32'hCAFEF00D, 1, 5'd14, 32'hCAFEF00D);
    ex_valid = 1'b1; ex_mem_op = MEM_LW; ex_alu_result = 32'h3002; ex_rd = 5'd3;
    push_exc(EXC_MISALIGN, 32'h3002);
    #1 chk("mis_stall", 32'(lsu_stall), 32'd0);
    step();
    ex_valid = 1'b0;
    chk("mis_noreq", 32'(dmem.req), 32'd0);
    step();
    ex_valid_b = 1'b1; ex_mem_op = MEM_SW; ex_alu_result = 32'h6000; ex_store_data = 32'h55;
    step();
    ex_valid_b = 1'b0;
    found = 1'b0; to_cause = '0; to_addr = '0; to_wb = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (exc_valid_b) begin
        found = 1'b1; to_cause = exc_cause_b; to_addr = exc_addr_b; to_wb = wb_valid_b;
      end else step();
    end
    chk("to_seen", 32'(found), 32'd1);
    chk("to_cause", 32'(to_cause), 32'(EXC_TIMEOUT));
    chk("to_addr", to_addr, 32'h6000);
    chk("to_no_wb", 32'(to_wb), 32'd0);
    chk("to_req_drop", 32'(dmem_b.req), 32'd0);
    step();
    issue(MEM_LW, 32'h7000, 32'd0, 5'd9);
    dmem.gnt = 1'b1;
    step();
    dmem.gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_req", 32'(dmem.req), 32'd0);
    chk("rstmid_stall", 32'(lsu_stall), 32'd0);
    chk("rstmid_wb", 32'(wb_valid), 32'd0);
    step();
    rst = 1'b0;
    dmem.rvalid = 1'b1; dmem.rdata = 32'h12345678;
    step();
    dmem.rvalid = 1'b0;
    chk("rst_late_wb", 32'(wb_valid), 32'd0);
    repeat (3) step();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
